// File: rtl/sub_serial_pkg.sv
// Shared definitions for the digit-serial subtractor: state encoding,
// default widths and the digit-counter width helper.
package sub_serial_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int DIGIT_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // A single-digit build still needs a one-bit counter.
  function automatic int digit_cnt_width(input int ndig);
    return (ndig > 1) ? $clog2(ndig) : 1;
  endfunction

endpackage

// File: rtl/sub_serial_32_digit_sub.sv
// Combinational DIGIT-bit subtract-with-borrow cell, reused for every digit.
module digit_sub #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             bin,
  output logic [DIGIT-1:0] d,
  output logic             bout
);

  logic [DIGIT:0] diff;

  // The extra top bit of the widened difference is the outgoing borrow.
  always_comb begin
    diff = {1'b0, a} - {1'b0, b} - (DIGIT + 1)'(bin);
  end

  assign d    = diff[DIGIT-1:0];
  assign bout = diff[DIGIT];

endmodule

// File: rtl/sub_serial_32.sv
// Multi-cycle subtractor D = A - B, one DIGIT per clock, LSD first.
// Optional macro SUB_SERIAL_SATURATE_EN clamps D to 0 on final borrow.
module sub_serial_32
  import sub_serial_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DIGIT = DIGIT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] D,
  output logic             BORROW
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int KW   = digit_cnt_width(NDIG);

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_RUN  = RUN;
  localparam logic [1:0] S_DONE = DONE;

  localparam logic [KW-1:0] K_LAST = KW'(NDIG - 1);

  logic [1:0]       state;
  logic [KW-1:0]    k;
  logic             br;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] d_reg;
  logic             borrow_reg;

  logic [DIGIT-1:0] a_dig;
  logic [DIGIT-1:0] b_dig;
  logic [DIGIT-1:0] d_dig;
  logic             bout;

  // Only the current digit of each operand feeds the shared cell.
  always_comb begin
    a_dig = a_reg[k*DIGIT +: DIGIT];
    b_dig = b_reg[k*DIGIT +: DIGIT];
  end

  digit_sub #(
    .DIGIT (DIGIT)
  ) u_digit_sub (
    .a    (a_dig),
    .b    (b_dig),
    .bin  (br),
    .d    (d_dig),
    .bout (bout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      k          <= '0;
      br         <= 1'b0;
      a_reg      <= '0;
      b_reg      <= '0;
      d_reg      <= '0;
      borrow_reg <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            a_reg <= A;
            b_reg <= B;
            k     <= '0;
            br    <= 1'b0;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          d_reg[k*DIGIT +: DIGIT] <= d_dig;
          br <= bout;
          if (k == K_LAST) begin
            k          <= '0;
            borrow_reg <= bout;
            state      <= S_DONE;
`ifdef SUB_SERIAL_SATURATE_EN
            // Later assignment overrides the last digit write above.
            if (bout) begin
              d_reg <= '0;
            end
`endif
          end else begin
            k <= k + 1'b1;
          end
        end
        S_DONE: begin
          if (start) begin
            a_reg <= A;
            b_reg <= B;
            k     <= '0;
            br    <= 1'b0;
            state <= S_RUN;
          end else begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy   = (state == S_RUN);
  assign done   = (state == S_DONE);
  assign D      = d_reg;
  assign BORROW = borrow_reg;

endmodule

// File: tb/tb_sub_serial_32.sv
// Self-checking bench for sub_serial_32: directed scenarios plus random
// operands checked against a plain-arithmetic reference model.
module tb_sub_serial_32;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic        done;
  logic [31:0] D;
  logic        BORROW;

  int checks;
  int failures;

  sub_serial_32 dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .A      (A),
    .B      (B),
    .busy   (busy),
    .done   (done),
    .D      (D),
    .BORROW (BORROW)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] model_d(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] diff;
    diff = a - b;
`ifdef SUB_SERIAL_SATURATE_EN
    if (a < b) diff = 32'd0;
`endif
    return diff;
  endfunction

  function automatic logic model_borrow(input logic [31:0] a, input logic [31:0] b);
    return a < b;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for done after an accepted start; returns edges counted incl. the start edge.
  task automatic wait_done(input string tag, output int lat);
    lat = 1;
    while (done !== 1'b1 && lat < 30) begin
      checkOutput({tag, "_busy"}, {31'd0, busy}, 32'd1);
      tick();
      lat++;
    end
    checkOutput({tag, "_latency"}, lat, 32'd9);
  endtask

  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input string tag);
    int lat;
    A = a;
    B = b;
    start = 1'b1;
    tick();
    start = 1'b0;
    A = $urandom;
    B = $urandom;
    wait_done(tag, lat);
    checkOutput({tag, "_done"}, {31'd0, done}, 32'd1);
    checkOutput({tag, "_D"}, D, model_d(a, b));
    checkOutput({tag, "_BORROW"}, {31'd0, BORROW}, {31'd0, model_borrow(a, b)});
    tick();
    checkOutput({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    int lat;
    int dones;
    logic [31:0] ra;
    logic [31:0] rb;
    checks   = 0;
    failures = 0;
    rst   = 1'b1;
    start = 1'b1;
    A     = 32'd9;
    B     = 32'd2;
    tick();
    tick();
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("reset_done", {31'd0, done}, 32'd0);
    checkOutput("reset_D", D, 32'd0);
    checkOutput("reset_BORROW", {31'd0, BORROW}, 32'd0);
    rst   = 1'b0;
    start = 1'b0;
    tick();
    checkOutput("idle_busy", {31'd0, busy}, 32'd0);

    applyStimulus(32'd45, 32'd27, "basic");
    applyStimulus(32'd0, 32'd1, "wrap");
    applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, "allones");
    applyStimulus(32'd142, 32'd33, "after_allones");

    // A start pulse with new operands during RUN must be ignored.
    A = 32'd5;
    B = 32'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    A = 32'd100;
    B = 32'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    lat = 4;
    while (done !== 1'b1 && lat < 30) begin
      tick();
      lat++;
    end
    checkOutput("ignore_latency", lat, 32'd9);
    checkOutput("ignore_D", D, 32'd2);
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done === 1'b1) dones++;
    end
    checkOutput("ignore_extra_done", dones, 32'd0);

    // Back-to-back: start held at the DONE cycle.
    A = 32'd10;
    B = 32'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("b2b_first", lat);
    checkOutput("b2b_first_D", D, 32'd7);
    A = 32'd1000;
    B = 32'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    checkOutput("b2b_restart_busy", {31'd0, busy}, 32'd1);
    wait_done("b2b_second", lat);
    checkOutput("b2b_second_D", D, 32'd999);
    checkOutput("b2b_second_BORROW", {31'd0, BORROW}, 32'd0);
    tick();

    // Reset in the middle of RUN aborts without a done pulse.
    A = 32'd50;
    B = 32'd20;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("abort_busy", {31'd0, busy}, 32'd0);
    checkOutput("abort_done", {31'd0, done}, 32'd0);
    checkOutput("abort_D", D, 32'd0);
    checkOutput("abort_BORROW", {31'd0, BORROW}, 32'd0);
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done === 1'b1) dones++;
    end
    checkOutput("abort_no_done", dones, 32'd0);
    applyStimulus(32'd7, 32'd7, "after_abort");

    for (int i = 0; i < 20; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i % 4 == 0) rb = ra + 32'($urandom_range(1, 50));
      applyStimulus(ra, rb, "random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
